// File: rtl/mem_access_ctrl.sv
// Load/store sequencer that drives a four-phase data memory and returns load data.
// Define MEM_ACCESS_CTRL_CLEAR_EN to build the zero-fill sweep (CLR state and ClearDone).
module mem_access_ctrl #(
    parameter int N = 256,
    parameter int W = 8,
    localparam int AW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Req,
    input  logic          Op,
    input  logic [AW-1:0] Addr,
    input  logic [W-1:0]  WData,
    input  logic          Init,
    output logic          Ready,
    output logic          Done,
    output logic [W-1:0]  RData,
    output logic          ClearDone,
    output logic [1:0]    Counter,
    output logic [AW-1:0] DataAddr,
    output logic          ReadMem,
    output logic          WriteMem,
    output logic [W-1:0]  DataIn,
    input  logic [W-1:0]  DataOut
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

`ifdef MEM_ACCESS_CTRL_CLEAR_EN
    typedef enum logic [1:0] {IDLE, ACC, CLR} state_t;
    logic clrdone_nxt;
`else
    typedef enum logic [1:0] {IDLE, ACC} state_t;
    logic unused_init;
    assign unused_init = Init;
`endif

    state_t        state, state_nxt;
    logic [1:0]    counter_nxt;
    logic [AW-1:0] addr_nxt;
    logic [W-1:0]  din_nxt;
    logic [W-1:0]  rdata_nxt;
    logic          rd_nxt;
    logic          wr_nxt;
    logic          done_nxt;

    assign Ready = (state == IDLE);

    // Every memory-side output is computed here and registered below, so nothing
    // reaches the memory combinationally from the core's inputs.
    always_comb begin
        state_nxt   = state;
        counter_nxt = Counter;
        addr_nxt    = DataAddr;
        din_nxt     = DataIn;
        rdata_nxt   = RData;
        rd_nxt      = ReadMem;
        wr_nxt      = WriteMem;
        done_nxt    = 1'b0;
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
        clrdone_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
                if (Init) begin
                    state_nxt   = CLR;
                    counter_nxt = 2'd0;
                    addr_nxt    = '0;
                    din_nxt     = '0;
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b1;
                end else
`endif
                if (Req) begin
                    state_nxt   = ACC;
                    counter_nxt = 2'd0;
                    addr_nxt    = Addr;
                    din_nxt     = WData;
                    rd_nxt      = !Op;
                    wr_nxt      = Op;
                end
            end
            ACC: begin
                counter_nxt = Counter + 2'd1;
                if (Counter == 2'd3) begin
                    if (ReadMem) begin
                        rdata_nxt = DataOut;
                    end
                    rd_nxt      = 1'b0;
                    wr_nxt      = 1'b0;
                    counter_nxt = 2'd0;
                    done_nxt    = 1'b1;
                    state_nxt   = IDLE;
                end
            end
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
            // One address per four phases; the address only advances at phase 3.
            CLR: begin
                counter_nxt = Counter + 2'd1;
                if (Counter == 2'd3) begin
                    counter_nxt = 2'd0;
                    if (DataAddr == LAST_ADDR) begin
                        wr_nxt      = 1'b0;
                        addr_nxt    = '0;
                        clrdone_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        addr_nxt = DataAddr + AW'(1);
                    end
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            Counter   <= 2'd0;
            DataAddr  <= '0;
            DataIn    <= '0;
            RData     <= '0;
            ReadMem   <= 1'b0;
            WriteMem  <= 1'b0;
            Done      <= 1'b0;
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
            ClearDone <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            Counter   <= counter_nxt;
            DataAddr  <= addr_nxt;
            DataIn    <= din_nxt;
            RData     <= rdata_nxt;
            ReadMem   <= rd_nxt;
            WriteMem  <= wr_nxt;
            Done      <= done_nxt;
`ifdef MEM_ACCESS_CTRL_CLEAR_EN
            ClearDone <= clrdone_nxt;
`endif
        end
    end

`ifndef MEM_ACCESS_CTRL_CLEAR_EN
    assign ClearDone = 1'b0;
`endif

endmodule
